// File: rtl/axi_lite_slave_dual_pkg.sv
// Shared definitions for the dual-engine AXI4-Lite slave: response codes,
// engine state encodings and the user-ack response helper.
package axi_lite_slave_dual_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_USER,
    WR_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_USER,
    RD_RESP
  } rd_state_t;

  // Response returned when the user side acknowledges an access.
  function automatic logic [1:0] ack_resp(input logic invalid);
    return invalid ? AXI_RESP_DECERR : AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_lite_timeout.sv
// Per-access user-ack watchdog. The counter restarts on start, then advances
// once per cycle; expired is high during the TIMEOUT_CYCLES-th waiting cycle.
// An ack or an expiry ends the watch. TIMEOUT_CYCLES of 0 disables expiry.
module axi_lite_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ack,
  output logic expired
);

  localparam int unsigned CW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  logic [CW-1:0] count;
  logic          running;

  assign expired = (TIMEOUT_CYCLES != 0) && running && (count == CW'(LAST));

  // Wait counter: cleared on start, stops on ack or expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      count   <= '0;
    end else if (start) begin
      running <= 1'b1;
      count   <= '0;
    end else if (running) begin
      if (ack || expired) begin
        running <= 1'b0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_lite_slave_dual.sv
// AXI4-Lite slave with independent read and write engines bridging to a
// simple request/ack register interface. AW and W are accepted in any order;
// every user access is guarded by its own timeout returning SLVERR.
module axi_lite_slave_dual
  import axi_lite_slave_dual_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned STROBE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_awvalid,
  output logic                    o_awready,
  input  logic [ADDR_WIDTH-1:0]   i_awaddr,
  input  logic                    i_wvalid,
  output logic                    o_wready,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [STROBE_WIDTH-1:0] i_wstrb,
  output logic                    o_bvalid,
  input  logic                    i_bready,
  output logic [1:0]              o_bresp,
  input  logic                    i_arvalid,
  output logic                    o_arready,
  input  logic [ADDR_WIDTH-1:0]   i_araddr,
  output logic                    o_rvalid,
  input  logic                    i_rready,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic [1:0]              o_rresp,
  output logic                    o_wr_req,
  output logic [ADDR_WIDTH-1:0]   o_wr_addr,
  output logic [DATA_WIDTH-1:0]   o_wr_data,
  output logic [STROBE_WIDTH-1:0] o_wr_strb,
  input  logic                    i_wr_ack_stb,
  input  logic                    i_wr_invalid,
  output logic                    o_rd_req,
  output logic [ADDR_WIDTH-1:0]   o_rd_addr,
  input  logic                    i_rd_ack_stb,
  input  logic [DATA_WIDTH-1:0]   i_rd_data,
  input  logic                    i_rd_invalid
);

  // ---------------------------------------------------------------- write --
  wr_state_t               wr_state, wr_state_d;
  logic                    aw_have, aw_have_d;
  logic                    w_have, w_have_d;
  logic                    awready_d, wready_d, bvalid_d, wr_req_d;
  logic [1:0]              bresp_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_d;
  logic [STROBE_WIDTH-1:0] wr_strb_d;
  logic                    aw_hs, w_hs;
  logic                    wr_start, wr_ack, wr_expired;

  assign aw_hs  = i_awvalid && o_awready;
  assign w_hs   = i_wvalid && o_wready;
  assign wr_ack = (wr_state == WR_USER) && i_wr_ack_stb;

  axi_lite_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wr_timeout (
    .clk    (clk),
    .rst    (rst),
    .start  (wr_start),
    .ack    (wr_ack),
    .expired(wr_expired)
  );

  // Write engine next state and next registered outputs.
  always_comb begin
    wr_state_d = wr_state;
    aw_have_d  = aw_have;
    w_have_d   = w_have;
    awready_d  = o_awready;
    wready_d   = o_wready;
    bvalid_d   = o_bvalid;
    bresp_d    = o_bresp;
    wr_req_d   = o_wr_req;
    wr_addr_d  = o_wr_addr;
    wr_data_d  = o_wr_data;
    wr_strb_d  = o_wr_strb;
    wr_start   = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (aw_hs) begin
          aw_have_d = 1'b1;
          wr_addr_d = i_awaddr;
        end
        if (w_hs) begin
          w_have_d  = 1'b1;
          wr_data_d = i_wdata;
          wr_strb_d = i_wstrb;
        end
        if (aw_have_d && w_have_d) begin
          wr_state_d = WR_USER;
          wr_req_d   = 1'b1;
          wr_start   = 1'b1;
          aw_have_d  = 1'b0;
          w_have_d   = 1'b0;
          awready_d  = 1'b0;
          wready_d   = 1'b0;
        end else begin
          awready_d = !aw_have_d;
          wready_d  = !w_have_d;
        end
      end
      WR_USER: begin
        if (i_wr_ack_stb) begin
          wr_state_d = WR_RESP;
          wr_req_d   = 1'b0;
          bvalid_d   = 1'b1;
          bresp_d    = ack_resp(i_wr_invalid);
        end else if (wr_expired) begin
          wr_state_d = WR_RESP;
          wr_req_d   = 1'b0;
          bvalid_d   = 1'b1;
          bresp_d    = AXI_RESP_SLVERR;
        end
      end
      WR_RESP: begin
        if (i_bready) begin
          wr_state_d = WR_IDLE;
          bvalid_d   = 1'b0;
          bresp_d    = AXI_RESP_OKAY;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Write engine state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state  <= WR_IDLE;
      aw_have   <= 1'b0;
      w_have    <= 1'b0;
      o_awready <= 1'b0;
      o_wready  <= 1'b0;
      o_bvalid  <= 1'b0;
      o_bresp   <= '0;
      o_wr_req  <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      o_wr_strb <= '0;
    end else begin
      wr_state  <= wr_state_d;
      aw_have   <= aw_have_d;
      w_have    <= w_have_d;
      o_awready <= awready_d;
      o_wready  <= wready_d;
      o_bvalid  <= bvalid_d;
      o_bresp   <= bresp_d;
      o_wr_req  <= wr_req_d;
      o_wr_addr <= wr_addr_d;
      o_wr_data <= wr_data_d;
      o_wr_strb <= wr_strb_d;
    end
  end

  // ----------------------------------------------------------------- read --
  rd_state_t             rd_state, rd_state_d;
  logic                  arready_d, rvalid_d, rd_req_d;
  logic [1:0]            rresp_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [ADDR_WIDTH-1:0] rd_addr_d;
  logic                  ar_hs;
  logic                  rd_start, rd_ack, rd_expired;

  assign ar_hs  = i_arvalid && o_arready;
  assign rd_ack = (rd_state == RD_USER) && i_rd_ack_stb;

  axi_lite_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rd_timeout (
    .clk    (clk),
    .rst    (rst),
    .start  (rd_start),
    .ack    (rd_ack),
    .expired(rd_expired)
  );

  // Read engine next state and next registered outputs.
  always_comb begin
    rd_state_d = rd_state;
    arready_d  = o_arready;
    rvalid_d   = o_rvalid;
    rresp_d    = o_rresp;
    rdata_d    = o_rdata;
    rd_req_d   = o_rd_req;
    rd_addr_d  = o_rd_addr;
    rd_start   = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        if (ar_hs) begin
          rd_state_d = RD_USER;
          rd_addr_d  = i_araddr;
          rd_req_d   = 1'b1;
          rd_start   = 1'b1;
          arready_d  = 1'b0;
        end else begin
          arready_d = 1'b1;
        end
      end
      RD_USER: begin
        if (i_rd_ack_stb) begin
          rd_state_d = RD_RESP;
          rd_req_d   = 1'b0;
          rvalid_d   = 1'b1;
          rdata_d    = i_rd_data;
          rresp_d    = ack_resp(i_rd_invalid);
        end else if (rd_expired) begin
          rd_state_d = RD_RESP;
          rd_req_d   = 1'b0;
          rvalid_d   = 1'b1;
          rdata_d    = '0;
          rresp_d    = AXI_RESP_SLVERR;
        end
      end
      RD_RESP: begin
        if (i_rready) begin
          rd_state_d = RD_IDLE;
          rvalid_d   = 1'b0;
          rresp_d    = AXI_RESP_OKAY;
          arready_d  = 1'b1;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Read engine state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state  <= RD_IDLE;
      o_arready <= 1'b0;
      o_rvalid  <= 1'b0;
      o_rresp   <= '0;
      o_rdata   <= '0;
      o_rd_req  <= 1'b0;
      o_rd_addr <= '0;
    end else begin
      rd_state  <= rd_state_d;
      o_arready <= arready_d;
      o_rvalid  <= rvalid_d;
      o_rresp   <= rresp_d;
      o_rdata   <= rdata_d;
      o_rd_req  <= rd_req_d;
      o_rd_addr <= rd_addr_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_dual.sv
// Directed and randomized checks of the dual-engine AXI4-Lite slave with a
// 16-cycle user-ack timeout.
module tb_axi_lite_slave_dual;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] araddr, rdata;
  logic        wr_req, wr_ack_stb, wr_invalid;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;
  logic        rd_req, rd_ack_stb, rd_invalid;
  logic [31:0] rd_addr, rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_lite_slave_dual #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_awvalid   (awvalid),
    .o_awready   (awready),
    .i_awaddr    (awaddr),
    .i_wvalid    (wvalid),
    .o_wready    (wready),
    .i_wdata     (wdata),
    .i_wstrb     (wstrb),
    .o_bvalid    (bvalid),
    .i_bready    (bready),
    .o_bresp     (bresp),
    .i_arvalid   (arvalid),
    .o_arready   (arready),
    .i_araddr    (araddr),
    .o_rvalid    (rvalid),
    .i_rready    (rready),
    .o_rdata     (rdata),
    .o_rresp     (rresp),
    .o_wr_req    (wr_req),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .o_wr_strb   (wr_strb),
    .i_wr_ack_stb(wr_ack_stb),
    .i_wr_invalid(wr_invalid),
    .o_rd_req    (rd_req),
    .o_rd_addr   (rd_addr),
    .i_rd_ack_stb(rd_ack_stb),
    .i_rd_data   (rd_data),
    .i_rd_invalid(rd_invalid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference response rules: expiry on the TMO-th waiting cycle unless acked in it.
  function automatic logic [1:0] exp_resp(input int delay, input logic inv);
    if (delay >= TMO) return 2'd2;
    return inv ? 2'd3 : 2'd0;
  endfunction

  function automatic int exp_req_cycles(input int delay);
    return (delay + 1 < TMO) ? delay + 1 : TMO;
  endfunction

  task automatic drive_aw();
    logic hs = 1'b0;
    awvalid = 1'b1;
    for (int k = 0; k < 50 && !hs; k++) begin
      hs = awready;
      tick();
    end
    awvalid = 1'b0;
    check("aw_handshake", hs, 1);
  endtask

  task automatic drive_w();
    logic hs = 1'b0;
    wvalid = 1'b1;
    for (int k = 0; k < 50 && !hs; k++) begin
      hs = wready;
      tick();
    end
    wvalid = 1'b0;
    check("w_handshake", hs, 1);
  endtask

  task automatic drive_ar();
    logic hs = 1'b0;
    arvalid = 1'b1;
    for (int k = 0; k < 50 && !hs; k++) begin
      hs = arready;
      tick();
    end
    arvalid = 1'b0;
    check("ar_handshake", hs, 1);
  endtask

  // order 0: AW and W together; 1: AW first; 2: W first, gap cycles apart.
  task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int order, input int gap);
    awaddr = a;
    wdata  = d;
    wstrb  = s;
    if (order == 0) begin
      logic ah, wh;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      for (int k = 0; k < 50 && (awvalid || wvalid); k++) begin
        ah = awvalid && awready;
        wh = wvalid && wready;
        tick();
        if (ah) awvalid = 1'b0;
        if (wh) wvalid = 1'b0;
      end
      check("aw_w_handshake", {awvalid, wvalid}, 0);
      awvalid = 1'b0;
      wvalid  = 1'b0;
    end else begin
      if (order == 1) drive_aw(); else drive_w();
      for (int k = 1; k < gap; k++) tick();
      check("wr_req_early", wr_req, 0);
      if (order == 1) drive_w(); else drive_aw();
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int order, input int gap, input int delay,
                          input logic inv, input int bdelay);
    int   n;
    logic held = 1'b1;
    logic [1:0] er = exp_resp(delay, inv);
    send_aw_w(a, d, s, order, gap);
    check("wr_req_rise", wr_req, 1);
    check("wr_payload", {wr_addr, wr_data}, {a, d});
    check("wr_strb", wr_strb, s);
    n = 0;
    while (wr_req && n < 40) begin
      if (n == delay) begin
        wr_ack_stb = 1'b1;
        wr_invalid = inv;
      end
      tick();
      wr_ack_stb = 1'b0;
      wr_invalid = 1'b0;
      n++;
    end
    check("wr_req_cycles", n, exp_req_cycles(delay));
    check("bvalid_set", bvalid, 1);
    check("bresp", bresp, er);
    for (int k = 0; k < bdelay; k++) begin
      tick();
      held = held && bvalid && (bresp == er);
    end
    check("bvalid_held", held, 1);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("bvalid_drop", bvalid, 0);
  endtask

  task automatic do_read(input logic [31:0] a, input int delay, input logic [31:0] d,
                         input logic inv, input int rdelay);
    int   n;
    logic held = 1'b1;
    logic [1:0]  er = exp_resp(delay, inv);
    logic [31:0] ed = (delay >= TMO) ? 32'd0 : d;
    araddr = a;
    drive_ar();
    check("rd_req_rise", rd_req, 1);
    check("rd_addr", rd_addr, a);
    n = 0;
    while (rd_req && n < 40) begin
      if (n == delay) begin
        rd_ack_stb = 1'b1;
        rd_invalid = inv;
        rd_data    = d;
      end else begin
        rd_data = $urandom;
      end
      tick();
      rd_ack_stb = 1'b0;
      rd_invalid = 1'b0;
      rd_data    = $urandom;
      n++;
    end
    check("rd_req_cycles", n, exp_req_cycles(delay));
    check("rvalid_set", rvalid, 1);
    check("rresp", rresp, er);
    check("rdata", rdata, ed);
    for (int k = 0; k < rdelay; k++) begin
      tick();
      held = held && rvalid && (rresp == er) && (rdata == ed);
    end
    check("rvalid_held", held, 1);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("rvalid_drop", rvalid, 0);
  endtask

  initial begin
    rst = 1'b1;
    awvalid = 0; awaddr = 0; wvalid = 0; wdata = 0; wstrb = 0; bready = 0;
    arvalid = 0; araddr = 0; rready = 0;
    wr_ack_stb = 0; wr_invalid = 0; rd_ack_stb = 0; rd_data = 0; rd_invalid = 0;
    repeat (3) tick();

    // Reset state and ready release timing.
    check("reset_outputs_zero",
          |{awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, wr_req,
            wr_addr, wr_data, wr_strb, rd_req, rd_addr}, 0);
    rst = 1'b0;
    check("ready_before_release", {awready, wready, arready}, 0);
    tick();
    check("ready_after_release", {awready, wready, arready}, 3'b111);

    // Acks while idle must be ignored.
    wr_ack_stb = 1'b1;
    rd_ack_stb = 1'b1;
    tick();
    wr_ack_stb = 1'b0;
    rd_ack_stb = 1'b0;
    tick();
    check("idle_ack_ignored", {bvalid, rvalid, wr_req, rd_req}, 0);

    // Same-cycle AW+W, ack three cycles after the handshake.
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 2, 1'b0, 0);
    // W ahead of AW by four cycles, partial strobe.
    do_write(32'h14, 32'h0000BEEF, 4'h3, 2, 4, 1, 1'b0, 1);
    // Zero strobe forwarded unchanged, undecoded address.
    do_write(32'h18, 32'h11223344, 4'h0, 1, 2, 0, 1'b1, 0);
    // Read with DECERR, response held under backpressure.
    do_read(32'h20, 1, 32'h12345678, 1'b1, 5);
    // Read timeout, then ack in the expiry cycle.
    do_read(32'h40, TMO + 4, 32'hFFFF0000, 1'b0, 0);
    do_read(32'h44, TMO - 1, 32'h87654321, 1'b0, 0);
    // Write timeout.
    do_write(32'h48, 32'hA5A5A5A5, 4'hC, 0, 0, TMO + 2, 1'b0, 0);

    // Read completes while a write waits for its ack.
    send_aw_w(32'h8, 32'hCAFEF00D, 4'hF, 0, 0);
    check("conc_wr_req", wr_req, 1);
    do_read(32'h4, 2, 32'h0BADCAFE, 1'b0, 0);
    check("conc_write_waiting", {wr_req, bvalid}, 2'b10);
    wr_ack_stb = 1'b1;
    tick();
    wr_ack_stb = 1'b0;
    check("conc_bvalid", {bvalid, bresp}, 3'b100);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("conc_bvalid_drop", bvalid, 0);

    // Reset while a write response is pending.
    send_aw_w(32'h30, 32'h55AA55AA, 4'hF, 0, 0);
    wr_ack_stb = 1'b1;
    tick();
    wr_ack_stb = 1'b0;
    check("rst_pre_bvalid", bvalid, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_outputs_zero",
          |{awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, wr_req,
            wr_addr, wr_data, wr_strb, rd_req, rd_addr}, 0);
    tick();
    check("rst_mid_ready", {awready, wready, arready}, 3'b111);
    do_write(32'h34, 32'h01020304, 4'h5, 0, 0, 3, 1'b0, 0);

    // Randomized transactions.
    for (int i = 0; i < 12; i++) begin
      int order = $urandom_range(0, 2);
      do_write($urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(0, 15)), order,
               $urandom_range(1, 4), $urandom_range(0, TMO + 3), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3));
      do_read($urandom & 32'hFFFF_FFFC, $urandom_range(0, TMO + 3), $urandom,
              1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
